// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : PC sequencing and single-outstanding instruction fetch with a
//            one-entry decode buffer and EX redirect handling.
//            Optional macro FETCH_MISALIGN_EN: misaligned redirects raise a
//            fetch fault instead of being silently aligned.
// Revision : 1.0
// ============================================================================
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_misalign
);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_req_addr;
    logic        r_if_valid;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_instr;
    logic        r_if_misalign;
    logic        r_park;
    logic        w_can_issue;
    logic        w_grant;
    logic        w_load;
    logic        w_redirect_misalign;
    logic [31:0] w_redirect_pc;

`ifdef FETCH_MISALIGN_EN
    assign w_redirect_misalign = redirect_valid & (redirect_pc[1:0] != 2'b00);
    assign w_redirect_pc       = redirect_pc;
`else
    assign w_redirect_misalign = 1'b0;
    assign w_redirect_pc       = {redirect_pc[31:2], 2'b00};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_REQ: begin
                if (w_grant) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_state_nxt = S_REQ;
                end else if (redirect_valid) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    // Only request when the buffer will be free, so a response never stalls.
    always_comb begin
        w_can_issue = !r_if_valid | if_ready;
        imem_req    = (r_state == S_REQ) & w_can_issue & !redirect_valid & !r_park & !rst;
        w_grant     = imem_req & imem_gnt;
        w_load      = (r_state == S_WAIT) & imem_rvalid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_req_addr    <= RESET_PC;
            r_if_valid    <= 1'b0;
            r_if_pc       <= 32'h0000_0000;
            r_if_instr    <= NOP_INSTR;
            r_if_misalign <= 1'b0;
            r_park        <= 1'b0;
        end else if (redirect_valid) begin
            r_pc   <= w_redirect_pc;
            r_park <= w_redirect_misalign;
            if (w_redirect_misalign) begin
                r_if_valid    <= 1'b1;
                r_if_pc       <= redirect_pc;
                r_if_instr    <= NOP_INSTR;
                r_if_misalign <= 1'b1;
            end else begin
                r_if_valid <= 1'b0;
            end
        end else begin
            if (w_grant) begin
                r_pc       <= r_pc + 32'd4;
                r_req_addr <= r_pc;
            end
            if (w_load) begin
                r_if_valid    <= 1'b1;
                r_if_pc       <= r_req_addr;
                r_if_instr    <= imem_rdata;
                r_if_misalign <= 1'b0;
            end else if (r_if_valid & if_ready) begin
                r_if_valid <= 1'b0;
            end
        end
    end

    assign imem_addr   = r_pc;
    assign if_valid    = r_if_valid;
    assign if_pc       = r_if_pc;
    assign if_instr    = r_if_valid ? r_if_instr : NOP_INSTR;
    assign if_misalign = r_if_misalign;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Directed self-checking bench for fetch_ctrl.
// Revision : 1.0
// ============================================================================
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_misalign;

    int n_cmp = 0;
    int n_err = 0;

    fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_misalign    (if_misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    // Drive one cycle's inputs mid-period; outputs are checked before the next rising edge.
    task automatic cyc(input logic rs, input logic rd, input logic [31:0] rpc,
                       input logic g, input logic rv, input logic [31:0] data,
                       input logic rdy);
        @(negedge clk);
        rst            = rs;
        redirect_valid = rd;
        redirect_pc    = rpc;
        imem_gnt       = g;
        imem_rvalid    = rv;
        imem_rdata     = data;
        if_ready       = rdy;
        #1;
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b1;

        // Reset state
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 1, 0, 0, 1);
        check_val("rst_req",      {31'b0, imem_req},    32'd0);
        check_val("rst_valid",    {31'b0, if_valid},    32'd0);
        check_val("rst_pc",       if_pc,                32'h0);
        check_val("rst_instr",    if_instr,             NOP);
        check_val("rst_misalign", {31'b0, if_misalign}, 32'd0);
        check_val("rst_addr",     imem_addr,            32'h0);

        // Zero-wait streaming
        cyc(0, 0, 0, 1, 0, 0, 1);
        check_val("s_req0",  {31'b0, imem_req}, 32'd1);
        check_val("s_addr0", imem_addr, 32'h0);
        cyc(0, 0, 0, 0, 1, mem_word(32'h0), 1);
        check_val("s_req_wait", {31'b0, imem_req}, 32'd0);
        check_val("s_nop0",     if_instr, NOP);
        cyc(0, 0, 0, 1, 0, 0, 1);
        check_val("s_pc0",    if_pc,     32'h0);
        check_val("s_instr0", if_instr,  mem_word(32'h0));
        check_val("s_addr4",  imem_addr, 32'h4);
        cyc(0, 0, 0, 0, 1, mem_word(32'h4), 1);
        check_val("s_nop1", if_instr, NOP);
        cyc(0, 0, 0, 1, 0, 0, 1);
        check_val("s_pc4",   if_pc,     32'h4);
        check_val("s_instr4", if_instr, mem_word(32'h4));
        check_val("s_addr8", imem_addr, 32'h8);
        cyc(0, 0, 0, 0, 1, mem_word(32'h8), 1);

        // Decode stall holds the entry and blocks new requests
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 1, 0, 0, 0);
            check_val("st_req",   {31'b0, imem_req}, 32'd0);
            check_val("st_valid", {31'b0, if_valid}, 32'd1);
            check_val("st_pc",    if_pc,    32'h8);
            check_val("st_instr", if_instr, mem_word(32'h8));
        end
        cyc(0, 0, 0, 1, 0, 0, 1);
        check_val("st_rel_req",  {31'b0, imem_req}, 32'd1);
        check_val("st_rel_addr", imem_addr, 32'hC);
        cyc(0, 0, 0, 0, 1, mem_word(32'hC), 1);
        cyc(0, 0, 0, 1, 0, 0, 1);
        check_val("s_pcC",   if_pc,     32'hC);
        check_val("s_addr10", imem_addr, 32'h10);

        // Redirect during WAIT, late response drained
        cyc(0, 1, 32'h100, 0, 0, 0, 1);
        check_val("rw_req", {31'b0, imem_req}, 32'd0);
        cyc(0, 0, 0, 1, 0, 0, 1);
        check_val("dr_req1", {31'b0, imem_req}, 32'd0);
        cyc(0, 0, 0, 1, 0, 0, 1);
        check_val("dr_req2", {31'b0, imem_req}, 32'd0);
        cyc(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 1);
        check_val("dr_req3", {31'b0, imem_req}, 32'd0);
        cyc(0, 0, 0, 1, 0, 0, 1);
        check_val("rw_valid", {31'b0, if_valid}, 32'd0);
        check_val("rw_req4",  {31'b0, imem_req}, 32'd1);
        check_val("rw_addr",  imem_addr, 32'h100);
        cyc(0, 0, 0, 0, 1, mem_word(32'h100), 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check_val("rw_fvalid", {31'b0, if_valid}, 32'd1);
        check_val("rw_pc",     if_pc,    32'h100);
        check_val("rw_instr",  if_instr, mem_word(32'h100));

        // Redirect coincident with rvalid
        cyc(0, 1, 32'h20, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0, 1);
        check_val("rv_addr20", imem_addr, 32'h20);
        cyc(0, 1, 32'h200, 0, 1, 32'hBAD0_0020, 1);
        check_val("rv_req", {31'b0, imem_req}, 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check_val("rv_valid", {31'b0, if_valid}, 32'd0);
        check_val("rv_req2",  {31'b0, imem_req}, 32'd1);
        check_val("rv_addr",  imem_addr, 32'h200);

        // Redirect in REQ with grant offered: request suppressed
        cyc(0, 1, 32'h300, 1, 0, 0, 1);
        check_val("rq_req", {31'b0, imem_req}, 32'd0);
        cyc(0, 0, 0, 1, 0, 0, 1);
        check_val("rq_addr", imem_addr, 32'h300);
        check_val("rq_req2", {31'b0, imem_req}, 32'd1);
        cyc(0, 0, 0, 0, 1, mem_word(32'h300), 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check_val("rq_pc", if_pc, 32'h300);

        // Address wrap
        cyc(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0, 1);
        check_val("wr_addr", imem_addr, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0, 1, mem_word(32'hFFFF_FFFC), 1);
        cyc(0, 0, 0, 1, 0, 0, 1);
        check_val("wr_pc",    if_pc,     32'hFFFF_FFFC);
        check_val("wr_addr0", imem_addr, 32'h0);
        check_val("wr_req",   {31'b0, imem_req}, 32'd1);

        // Reset mid-WAIT, late rvalid ignored
        cyc(1, 0, 0, 0, 0, 0, 1);
        check_val("rm_req", {31'b0, imem_req}, 32'd0);
        cyc(0, 0, 0, 0, 1, 32'hBAD0_0000, 1);
        check_val("rm_valid", {31'b0, if_valid}, 32'd0);
        check_val("rm_addr",  imem_addr, 32'h0);
        check_val("rm_req2",  {31'b0, imem_req}, 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check_val("rm_late", {31'b0, if_valid}, 32'd0);

        // Misaligned redirect
        cyc(0, 1, 32'h102, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0, 1);
`ifdef FETCH_MISALIGN_EN
        check_val("ma_req",      {31'b0, imem_req},    32'd0);
        check_val("ma_valid",    {31'b0, if_valid},    32'd1);
        check_val("ma_misalign", {31'b0, if_misalign}, 32'd1);
        check_val("ma_pc",       if_pc,                32'h102);
        check_val("ma_instr",    if_instr,             NOP);
        cyc(0, 0, 0, 1, 0, 0, 1);
        check_val("ma_park", {31'b0, imem_req}, 32'd0);
`else
        check_val("ma_req",      {31'b0, imem_req},    32'd1);
        check_val("ma_addr",     imem_addr,            32'h100);
        check_val("ma_misalign", {31'b0, if_misalign}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the program counter and the instruction-memory fetch for the pipelined core.
- Owns the architectural fetch PC and issues one outstanding request at a time over a req/gnt/rvalid handshake.
- Buffers one fetched instruction toward decode under a valid/ready handshake.
- Applies redirects from EX (taken branch, JAL, JALR) with priority, killing any in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
NOP_INSTR, 32'h0000_0013, value driven on if_instr when the buffer is empty (addi x0,x0,0)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
redirect_valid  in  1  EX requests PC change this cycle
redirect_pc  in  32  redirect target (PC+IMM or ALU result)
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address
imem_gnt  in  1  memory accepts request this cycle
imem_rvalid  in  1  response data valid (earliest 1 cycle after gnt)
imem_rdata  in  32  fetched instruction
if_valid  out  1  buffered instruction valid toward decode
if_ready  in  1  decode accepts (low = pipeline stall)
if_pc  out  32  PC of buffered instruction
if_instr  out  32  buffered instruction, NOP_INSTR when if_valid=0
if_misalign  out  1  buffered entry is a misaligned-fetch fault

Behaviour:
- Internal state: pc_q (next address to fetch), a one-entry output buffer, and the FSM REQ / WAIT / DRAIN.
- Reset (sync, rst=1 at posedge):
  - pc_q=RESET_PC, state=REQ.
  - if_valid=0, if_pc=0, if_instr=NOP_INSTR, if_misalign=0.
  - imem_req=0 during the reset cycle; imem_addr=pc_q.
  - Reset overrides every other input, including mid-transaction. A pending rvalid after reset is ignored because the state is REQ.
- can_issue = !if_valid | if_ready. A request is issued only when the buffer is empty or is being drained this cycle, so a response always finds the buffer free.
- REQ:
  - imem_req=can_issue & !redirect_valid, imem_addr=pc_q.
  - On req & gnt: pc_q<=pc_q+4 (mod 2^32, wraps 0xFFFF_FFFC->0), then go to WAIT.
- WAIT:
  - imem_req=0.
  - On rvalid: load the buffer (if_valid<=1, if_pc<=address of the request, if_instr<=imem_rdata), then go to REQ. The address of each granted request is held in a register.
- DRAIN:
  - imem_req=0.
  - On rvalid: discard the data, then go to REQ.
- Redirect (redirect_valid=1), highest priority:
  - pc_q<=redirect_pc.
  - Buffer flushed: if_valid<=0.
  - Next state, by current state:
    - REQ with no grant: stay in REQ. No request is issued that cycle because imem_req is forced low.
    - WAIT without rvalid: go to DRAIN.
    - WAIT with rvalid in the same cycle: data discarded, go to REQ.
    - DRAIN: stay in DRAIN, or go to REQ if rvalid; pc_q is updated either way.
- Decode handshake:
  - if_valid & if_ready: the entry is consumed; if_valid<=0 unless a new response loads the buffer in the same cycle.
  - if_valid & !if_ready: if_pc, if_instr and if_misalign hold stable.
- Latency:
  - Redirect at cycle t: imem_req for the target is asserted at t+1 (if not in DRAIN).
  - Zero-wait memory (gnt same cycle, rvalid next cycle): if_valid rises 2 cycles after the request; throughput is 1 instruction per 2 cycles.

Optional Feature:
FETCH_MISALIGN_EN
- Defined:
  - A redirect with redirect_pc[1:0]!=0 does not fetch.
  - The next cycle loads the buffer with if_valid=1, if_misalign=1, if_pc=redirect_pc, if_instr=NOP_INSTR.
  - The FSM then parks in REQ with imem_req=0 until the next redirect or reset.
- Undefined:
  - redirect_pc[1:0] is forced to 2'b00 when loaded into pc_q.
  - if_misalign is tied to 0.

Test Plan:
- Reset then gnt=1 every cycle, rvalid 1 cycle after gnt, if_ready=1 -> imem_addr sequence 0x0,0x4,0x8; if_pc 0x0,0x4,0x8 with matching rdata; if_instr=0x00000013 whenever if_valid=0.
- if_ready=0 for 5 cycles with if_valid=1, if_pc=0x8 -> imem_req stays 0, if_pc/if_instr hold; when if_ready rises, the next request issues for 0xC in the same cycle.
- Redirect to 0x100 while in WAIT for 0x10, rvalid 3 cycles later -> that rdata is never presented; next imem_addr=0x100; if_pc=0x100 is the first valid entry.
- Redirect to 0x200 in the same cycle as rvalid for 0x20 -> data dropped, imem_req with addr 0x200 on the next cycle; redirect to 0x300 in REQ with gnt=0 -> no request for the old pc_q, next address 0x300.
- Redirect to 0xFFFF_FFFC -> fetch 0xFFFF_FFFC then 0x0000_0000 (wrap); rst asserted mid-WAIT -> next cycle if_valid=0, imem_addr=RESET_PC, late rvalid ignored.
- With FETCH_MISALIGN_EN, redirect to 0x102 -> no imem_req; if_valid=1, if_misalign=1, if_pc=0x102; without the macro -> fetch at 0x100.
